dmem_responder: RTL

Data-memory responder answering the MIPS pipeline's MEM-stage load/store requests over a valid/ready request channel and a one-cycle response pulse. It models a multi-cycle data memory with configurable latency, range checking and error signalling. While it is busy, `busy` holds the pipeline's MEM stage stalled. It sits between the pipeline's MEM stage and the word-addressed data array.

---
 rtl/dmem_pkg.sv | 6 +
 rtl/dmem_array.sv | 27 ++
 rtl/dmem_responder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
  localparam int WORD_W = 32;
  localparam int BE_W   = 4;
endpackage

// File: rtl/dmem_array.sv
// Word-addressed data array: combinational read, synchronous byte-lane write.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [BE_W-1:0]   i_be,
  input  logic [AW-1:0]     i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [WORD_W-1:0] o_rdata
);
  logic [WORD_W-1:0] r_mem [DEPTH_WORDS];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (i_be[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the MEM stage (IDLE/WAIT/RESP FSM, range/alignment faults).
// Optional byte-lane stores with DMEM_BYTE_WRITE_EN; otherwise full-word stores with alignment check.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  input  logic              i_req_write,
  input  logic [31:0]       i_req_addr,
  input  logic [WORD_W-1:0] i_req_wdata,
`ifdef DMEM_BYTE_WRITE_EN
  input  logic [BE_W-1:0]   i_req_be,
`endif
  output logic              o_req_ready,
  output logic              o_resp_valid,
  output logic [WORD_W-1:0] o_resp_rdata,
  output logic              o_resp_err,
  output logic              o_busy
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  dmem_state_t       r_state;
  logic [3:0]        r_cnt;
  logic [AW-1:0]     r_idx;
  logic [WORD_W-1:0] r_wdata;
  logic              r_write;
  logic              r_err;
  logic [BE_W-1:0]   r_be;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic [WORD_W-1:0] r_resp_rdata;
  logic              r_resp_err;
  logic              r_busy;

  logic              w_oor;
  logic              w_misalign;
  logic              w_req_err;
  logic [AW-1:0]     w_req_idx;
  logic [BE_W-1:0]   w_req_be;
  logic [AW-1:0]     w_rd_idx;
  logic [WORD_W-1:0] w_rd_data;
  logic              w_err_now;
  logic              w_write_now;
  logic [WORD_W-1:0] w_resp_data;
  logic              w_we;

  assign w_oor     = (i_req_addr[31:2] >= 30'(DEPTH_WORDS));
  assign w_req_idx = i_req_addr[AW+1:2];
`ifdef DMEM_BYTE_WRITE_EN
  assign w_misalign = 1'b0;
  assign w_req_be   = i_req_be;
`else
  assign w_misalign = |i_req_addr[1:0];
  assign w_req_be   = 4'hF;
`endif
  assign w_req_err = w_oor | w_misalign;

  // With LATENCY==1 RESP is entered straight from the accept, so read data must come from the live request.
  assign w_rd_idx    = (r_state == IDLE) ? w_req_idx : r_idx;
  assign w_err_now   = (r_state == IDLE) ? w_req_err : r_err;
  assign w_write_now = (r_state == IDLE) ? i_req_write : r_write;
  assign w_resp_data = (w_err_now || w_write_now) ? '0 : w_rd_data;

  // A reset landing on RESP must cancel the pending store.
  assign w_we = (r_state == RESP) && r_write && !r_err && !i_rst;

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_be    (r_be),
    .i_waddr (r_idx),
    .i_wdata (r_wdata),
    .i_raddr (w_rd_idx),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_idx       <= w_req_idx;
            r_wdata     <= i_req_wdata;
            r_write     <= i_req_write;
            r_be        <= w_req_be;
            r_err       <= w_req_err;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (LATENCY == 1) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= w_err_now;
              r_resp_rdata <= w_resp_data;
            end else begin
              r_cnt   <= CNT_INIT;
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= w_err_now;
            r_resp_rdata <= w_resp_data;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_req_ready  <= 1'b1;
          r_busy       <= 1'b0;
          r_resp_valid <= 1'b0;
          r_resp_rdata <= '0;
          r_resp_err   <= 1'b0;
        end
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid && !i_rst;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;
  assign o_busy       = r_busy;
endmodule
